// File: rtl/ram_write_buffer_if.sv
// ram_write_buffer_if: CPU store handshake into the write buffer.
interface ram_write_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  st_valid;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_ready;
  modport master (output st_valid, st_addr, st_data, input st_ready);
  modport slave (input st_valid, st_addr, st_data, output st_ready);
endinterface

// File: rtl/ram_write_buffer.sv
// ram_write_buffer: in-order store FIFO draining into a RAM, with load forwarding.
module ram_write_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  ram_write_buffer_if.slave            st,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  output logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         drain_en,
  output logic [DATA_WIDTH-1:0]        ram_data,
  output logic [ADDR_WIDTH-1:0]        ram_write_addr,
  output logic                         ram_we,
  output logic [ADDR_WIDTH-1:0]        ram_read_addr,
  input  logic [DATA_WIDTH-1:0]        ram_out,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow_err
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head, tail, idx;
  logic                  push, pop;
  assign st.st_ready     = count < (PW+1)'(DEPTH);
  assign empty           = count == '0;
  assign ram_we          = drain_en & ~empty;
  assign ram_write_addr  = addr_q[head];
  assign ram_data        = data_q[head];
  assign ram_read_addr   = ld_addr;
  assign push            = st.st_valid & st.st_ready;
  assign pop             = ram_we;
  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    ld_data = ram_out;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && addr_q[idx] == ld_addr) ld_data = data_q[idx];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid_q      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        addr_q[tail]  <= st.st_addr;
        data_q[tail]  <= st.st_data;
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (st.st_valid && !st.st_ready) overflow_err <= 1'b1;
    end
  end
endmodule
